// File: rtl/pwm_pkg.sv
// PWM link shared definitions.
// Common to the pwm_dac transmit side and the pwm_decoder receive side.
package pwm_pkg;

  localparam int PWM_CNT_W = 4;

  typedef enum logic [1:0] {
    PWM_DEC_IDLE,
    PWM_DEC_ACQUIRE,
    PWM_DEC_MEASURE
  } pwm_dec_state_e;

endpackage

// File: rtl/pwm_decoder_sync_ff.sv
// Multi-stage flop synchroniser for a single asynchronous bit.
// Clears to 0 on reset.
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr <= '0;
    end else begin
      sr <= {sr[STAGES-2:0], d};
    end
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/pwm_decoder.sv
// PWM duty decoder: counts high cycles of pwm_i per 2**CNT_W window
// and hands each result out on a valid/ready port.
module pwm_decoder
  import pwm_pkg::*;
#(
  parameter int CNT_W       = PWM_CNT_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk_i,
  input  logic           rst_i,
  input  logic           en_i,
  input  logic           pwm_i,
  input  logic           ready_i,
  input  logic           clr_i,
  output logic [CNT_W:0] duty_o,
  output logic           valid_o,
  output logic           locked_o,
  output logic           overrun_o
);

  localparam int ACQ_W = $clog2(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0] WIN_LAST = '1;
  localparam logic [ACQ_W-1:0] ACQ_LAST = ACQ_W'(SYNC_STAGES - 1);

  pwm_dec_state_e state;

  logic             pwm_s;
  logic [CNT_W-1:0] win_q;
  logic [CNT_W:0]   high_q;
  logic [CNT_W:0]   prev_q;
  logic             prev_vld;
  logic [ACQ_W-1:0] acq_q;
  logic [CNT_W:0]   result;
  logic             res_vld;
  logic             xfer;
  logic             ovr_set;

  sync_ff #(
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .clk(clk_i),
    .rst(rst_i),
    .d  (pwm_i),
    .q  (pwm_s)
  );

  // Last sample of the window is folded in directly.
  assign result  = high_q + {{CNT_W{1'b0}}, pwm_s};
  assign res_vld = en_i && (state == PWM_DEC_MEASURE)
                   && (win_q == WIN_LAST);
  assign xfer    = valid_o && ready_i;
  assign ovr_set = res_vld && valid_o && !ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= PWM_DEC_IDLE;
      win_q     <= '0;
      high_q    <= '0;
      prev_q    <= '0;
      prev_vld  <= 1'b0;
      acq_q     <= '0;
      duty_o    <= '0;
      valid_o   <= 1'b0;
      locked_o  <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      if (ovr_set) begin
        overrun_o <= 1'b1;
      end else if (clr_i) begin
        overrun_o <= 1'b0;
      end

      if (!en_i) begin
        state    <= PWM_DEC_IDLE;
        win_q    <= '0;
        high_q   <= '0;
        acq_q    <= '0;
        valid_o  <= 1'b0;
        locked_o <= 1'b0;
        prev_vld <= 1'b0;
      end else begin
        unique case (state)
          PWM_DEC_IDLE: begin
            state <= PWM_DEC_ACQUIRE;
            acq_q <= '0;
          end
          // Wait out stale synchroniser contents.
          PWM_DEC_ACQUIRE: begin
            if (acq_q == ACQ_LAST) begin
              state  <= PWM_DEC_MEASURE;
              win_q  <= '0;
              high_q <= '0;
            end else begin
              acq_q <= acq_q + 1'b1;
            end
          end
          PWM_DEC_MEASURE: begin
            if (res_vld) begin
              duty_o   <= result;
              valid_o  <= 1'b1;
              locked_o <= prev_vld && (result == prev_q);
              prev_q   <= result;
              prev_vld <= 1'b1;
              win_q    <= '0;
              high_q   <= '0;
            end else begin
              win_q  <= win_q + 1'b1;
              high_q <= result;
              if (xfer) begin
                valid_o <= 1'b0;
              end
            end
          end
          default: state <= PWM_DEC_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_decoder.sv
// Self-checking bench for pwm_decoder: cycle model plus directed
// sequences for latency, overrun, transition and abort cases.
module tb_pwm_decoder;

  localparam int W = 16;

  typedef enum int {M_PWM, M_HI, M_LO} mode_t;

  typedef struct {
    mode_t mode;
    int    set;
    int    exp;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       pwm = 1'b0;
  logic       ready = 1'b1;
  logic       clr = 1'b0;
  logic [4:0] duty;
  logic       valid;
  logic       locked;
  logic       overrun;

  pwm_decoder dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .en_i     (en),
    .pwm_i    (pwm),
    .ready_i  (ready),
    .clr_i    (clr),
    .duty_o   (duty),
    .valid_o  (valid),
    .locked_o (locked),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  // Transmit-side stand-in: free-running 16-cycle PWM.
  mode_t mode = M_PWM;
  int    set = 0;
  int    pcnt = 0;

  always @(negedge clk) begin
    pcnt = (pcnt + 1) % W;
    case (mode)
      M_HI:    pwm = 1'b1;
      M_LO:    pwm = 1'b0;
      default: pwm = (pcnt < set);
    endcase
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d want %0d at %0t", nm, act, req, $time);
    end
  endtask

  // Transaction-level model: results appear every 16 cycles, the first
  // one 18 cycles after enable is sampled; value is the steady duty.
  int         exp_val = 0;
  bit         dc = 1'b0;
  bit         chk_on = 1'b0;
  logic [4:0] m_duty;
  logic       m_valid, m_lock, m_over;
  int         m_age, m_n, m_last;
  int         age;
  bit         res;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_duty  <= '0;
      m_valid <= 1'b0;
      m_lock  <= 1'b0;
      m_over  <= 1'b0;
      m_age   <= -1;
      m_n     <= 0;
      m_last  <= 0;
    end else if (!en) begin
      m_valid <= 1'b0;
      m_lock  <= 1'b0;
      m_age   <= -1;
      m_n     <= 0;
      if (clr) m_over <= 1'b0;
    end else begin
      age = m_age + 1;
      res = (age >= 18) && ((age - 18) % W == 0);
      if (res) begin
        m_duty  <= 5'(exp_val);
        m_valid <= 1'b1;
        m_lock  <= (m_n > 0) && (exp_val == m_last);
        m_last  <= exp_val;
        m_n     <= m_n + 1;
      end else if (m_valid && ready) begin
        m_valid <= 1'b0;
      end
      if (res && m_valid && !ready) m_over <= 1'b1;
      else if (clr) m_over <= 1'b0;
      m_age <= age;
    end
  end

  always @(posedge clk) begin
    #3;
    if (chk_on) begin
      chk("valid", valid, m_valid);
      chk("overrun", overrun, m_over);
      if (!dc) begin
        chk("duty", duty, m_duty);
        chk("locked", locked, m_lock);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_duty"}, duty, 0);
    chk({nm, "_valid"}, valid, 0);
    chk({nm, "_locked"}, locked, 0);
    chk({nm, "_overrun"}, overrun, 0);
  endtask

  task automatic first_latency(input string nm);
    int lat;
    lat = -1;
    for (int n = 1; n <= 30 && lat < 0; n++) begin
      @(posedge clk);
      #3;
      if (valid) lat = n;
    end
    chk(nm, lat, 19);
  endtask

  vec_t tbl[5];
  int   r1;
  int   len;
  int   k;

  initial begin
    tbl[0] = '{M_PWM, 0, 0};
    tbl[1] = '{M_PWM, 15, 15};
    tbl[2] = '{M_HI, 0, 16};
    tbl[3] = '{M_LO, 0, 0};
    tbl[4] = '{M_PWM, 11, 11};

    // Reset and idle
    #1 rst = 1'b1;
    #1 chk_reset("rst");
    chk_on = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cyc(40);
    chk("idle_valid", valid, 0);

    // Loopback at every phase offset
    mode = M_PWM; set = 5; exp_val = 5; ready = 1'b1;
    cyc(20);
    for (int off = 0; off < W; off++) begin
      for (int i = 0; i < W && pcnt != off; i++) @(negedge clk);
      en = 1'b1;
      first_latency("loop_latency");
      cyc(40);
      chk("loop_duty", duty, 5);
      chk("loop_locked", locked, 1);
      en = 1'b0;
      cyc(3);
    end

    // Extremes from the table
    for (int i = 0; i < 5; i++) begin
      en = 1'b0;
      mode = tbl[i].mode; set = tbl[i].set; exp_val = tbl[i].exp;
      cyc(20);
      en = 1'b1;
      cyc(51);
      chk("tbl_duty", duty, tbl[i].exp);
      chk("tbl_locked", locked, 1);
      chk("tbl_valid", valid, 1);
      en = 1'b0;
      cyc(3);
    end

    // Overrun, clear, clear coincident with new overrun
    mode = M_PWM; set = 7; exp_val = 7; ready = 1'b0;
    cyc(20);
    en = 1'b1;
    cyc(38);
    chk("ovr_flag", overrun, 1);
    chk("ovr_duty", duty, 7);
    chk("ovr_valid", valid, 1);
    cyc(2);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(1);
    chk("ovr_cleared", overrun, 0);
    cyc(8);
    clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    en = 1'b0; ready = 1'b1; clr = 1'b1;
    cyc(1);
    clr = 1'b0;
    cyc(2);

    // Duty change mid-stream
    set = 5; exp_val = 5; dc = 1'b1;
    cyc(20);
    en = 1'b1;
    cyc(43);
    set = 9; exp_val = 9;
    cyc(8);
    r1 = int'(duty);
    chk("trans_range", (r1 >= 5 && r1 <= 9), 1);
    chk("trans_locked", locked, (r1 == 5));
    cyc(16);
    chk("trans_duty2", duty, 9);
    chk("trans_locked2", locked, (r1 == 9));
    cyc(16);
    chk("trans_duty3", duty, 9);
    chk("trans_locked3", locked, 1);
    en = 1'b0;
    cyc(1);
    dc = 1'b0;
    cyc(2);

    // Abort mid-window, then re-enable
    set = 3; exp_val = 3; ready = 1'b0;
    cyc(20);
    en = 1'b1;
    cyc(27);
    chk("abort_pre_valid", valid, 1);
    en = 1'b0;
    cyc(1);
    chk("abort_valid", valid, 0);
    cyc(12);
    ready = 1'b1;
    en = 1'b1;
    first_latency("reen_latency");
    chk("reen_duty", duty, 3);
    chk("reen_locked", locked, 0);
    @(negedge clk);
    en = 1'b0;
    cyc(3);

    // Randomised episodes against the model
    for (int ep = 0; ep < 14; ep++) begin
      en = 1'b0; ready = 1'b1; clr = 1'b0;
      k = $urandom_range(0, 3);
      mode = (k == 1) ? M_HI : (k == 2) ? M_LO : M_PWM;
      set = $urandom_range(0, 15);
      exp_val = (mode == M_HI) ? 16 : (mode == M_LO) ? 0 : set;
      cyc(20);
      cyc($urandom_range(0, 15));
      en = 1'b1;
      len = $urandom_range(30, 90);
      for (int c = 0; c < len; c++) begin
        @(negedge clk);
        ready = 1'($urandom_range(0, 1));
        clr = ($urandom_range(0, 7) == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        rst = 1'b1;
        en = 1'b0;
        #1 chk_reset("rnd_rst");
        @(negedge clk);
        rst = 1'b0;
      end
    end

    en = 1'b0;
    cyc(2);
    chk_on = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
